// File: rtl/uart_defs.sv
// Shared definitions for the UART byte transmitter: FSM encoding and frame timing.
package uart_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Start bit + 8 data bits + stop bit.
  localparam int FRAME_BITS = 10;

  function automatic int bit_cyc(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/sync_byte_fifo.sv
// Byte queue with a first-word-fall-through head; a push when full is accepted if a pop happens the same cycle.
module sync_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     sys_clk,
  input  logic                     rst_n,
  input  logic                     wr,
  input  logic [7:0]               din,
  input  logic                     rd,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign pop  = rd && (count != '0);
  assign push = wr && ((count < FULL) || pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/uart_byte_tx.sv
// UART 8N1 transmitter fed from a small byte queue; tx, busy and ovf are all registered.
module uart_byte_tx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600,
  parameter int DEPTH    = 4
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_en,
  output logic       tx,
  output logic       busy,
  output logic       ovf
);

  import uart_defs::*;

  localparam int BIT_CYC = bit_cyc(CLK_FREQ, BAUD);
  localparam int CW      = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam int QW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BIT_CYC - 1);
  localparam logic [QW-1:0] Q_FULL    = QW'(DEPTH);
  localparam logic [2:0]    LAST_BIT  = 3'(FRAME_BITS - 3);

  uart_state_t   state;
  uart_state_t   state_nxt;
  logic [CW-1:0] baud_cnt;
  logic [CW-1:0] baud_nxt;
  logic [2:0]    bit_cnt;
  logic [2:0]    bit_nxt;
  logic [7:0]    sh;
  logic [7:0]    sh_nxt;
  logic          tx_q;
  logic          tx_nxt;
  logic          busy_q;
  logic          ovf_q;
  logic          pop;
  logic          bit_end;
  logic [7:0]    head;
  logic [QW-1:0] count;

  sync_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .wr      (tx_en),
    .din     (tx_data),
    .rd      (pop),
    .dout    (head),
    .count   (count)
  );

  assign bit_end = (baud_cnt == BAUD_LAST);

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    sh_nxt    = sh;
    tx_nxt    = tx_q;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        tx_nxt = 1'b1;
        if (count != '0) begin
          pop       = 1'b1;
          sh_nxt    = head;
          bit_nxt   = 3'd0;
          baud_nxt  = '0;
          tx_nxt    = 1'b0;
          state_nxt = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_nxt  = '0;
          tx_nxt    = sh[0];
          state_nxt = DATA;
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_nxt = '0;
          if (bit_cnt == LAST_BIT) begin
            tx_nxt    = 1'b1;
            state_nxt = STOP;
          end else begin
            // sh[1] becomes the new LSB, so it is the next line bit.
            sh_nxt  = {1'b0, sh[7:1]};
            tx_nxt  = sh[1];
            bit_nxt = bit_cnt + 1'b1;
          end
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_nxt  = '0;
          state_nxt = IDLE;
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= 3'd0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      tx_q     <= tx_nxt;
      busy_q   <= (state != IDLE) || (count != '0);
      // A full queue only rejects when no pop frees a slot this cycle.
      ovf_q    <= tx_en && (count == Q_FULL) && !pop;
    end
  end

  always_ff @(posedge sys_clk) begin
    sh <= sh_nxt;
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Directed bench: a fast instance (10 cycles/bit) for queue/FSM cases and a default-rate instance for bit timing.
module tb_uart_byte_tx;

  import uart_defs::*;

  localparam int BC      = 10;
  localparam int BC_SLOW = 50_000_000 / 9600;

  logic       sys_clk   = 1'b0;
  logic       rst_n     = 1'b0;
  logic       tx_en_f   = 1'b0;
  logic       tx_en_s   = 1'b0;
  logic [7:0] tx_data_f = 8'h00;
  logic [7:0] tx_data_s = 8'h00;
  logic       tx_f, busy_f, ovf_f;
  logic       tx_s, busy_s, ovf_s;

  int vectors     = 0;
  int miscompares = 0;
  int ovf_cnt     = 0;
  int ovf_base    = 0;

  always #5 sys_clk = ~sys_clk;

  uart_byte_tx #(
    .CLK_FREQ (50_000_000),
    .BAUD     (5_000_000),
    .DEPTH    (4)
  ) u_fast (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .tx_data (tx_data_f),
    .tx_en   (tx_en_f),
    .tx      (tx_f),
    .busy    (busy_f),
    .ovf     (ovf_f)
  );

  uart_byte_tx u_slow (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .tx_data (tx_data_s),
    .tx_en   (tx_en_s),
    .tx      (tx_s),
    .busy    (busy_s),
    .ovf     (ovf_s)
  );

  always @(posedge sys_clk) begin
    if (ovf_f === 1'b1) ovf_cnt <= ovf_cnt + 1;
  end

  function automatic logic line(input logic sel);
    return sel ? tx_s : tx_f;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after the edge that dropped tx (minus 'elapsed' cycles already spent in the start bit).
  task automatic expect_frame(input logic sel, input logic [7:0] b, input int bc,
                              input int elapsed, input string tag);
    logic e;
    int   n;
    for (int i = 0; i < FRAME_BITS; i++) begin
      e = (i == 0) ? 1'b0 : (i == FRAME_BITS - 1) ? 1'b1 : b[i-1];
      n = (i == 0) ? bc - elapsed : bc;
      chk(line(sel), e, $sformatf("%s bit%0d first", tag, i));
      tick(n - 1);
      chk(line(sel), e, $sformatf("%s bit%0d last", tag, i));
      tick(1);
    end
  endtask

  task automatic gap(input string tag);
    chk(tx_f, 1'b1, tag);
    tick(1);
  endtask

  task automatic quiet(input int n, input string tag);
    logic low;
    low = 1'b0;
    repeat (n) begin
      if (tx_f !== 1'b1) low = 1'b1;
      tick(1);
    end
    chk(low, 1'b0, tag);
  endtask

  initial begin
    // Reset state
    tick(3);
    chk(tx_f, 1'b1, "rst tx");
    chk(busy_f, 1'b0, "rst busy");
    chk(ovf_f, 1'b0, "rst ovf");
    chk(tx_s, 1'b1, "rst tx_s");
    rst_n = 1'b1;
    tick(2);

    // Single byte A5
    tx_data_f = 8'hA5; tx_en_f = 1'b1;
    tick(1);
    tx_en_f = 1'b0;
    chk(tx_f, 1'b1, "sb tx e0");
    chk(busy_f, 1'b0, "sb busy e0");
    tick(1);
    chk(busy_f, 1'b1, "sb busy e1");
    expect_frame(1'b0, 8'hA5, BC, 0, "sb");
    chk(busy_f, 1'b1, "sb busy e101");
    tick(1);
    chk(busy_f, 1'b0, "sb busy e102");
    chk(tx_f, 1'b1, "sb idle tx");
    tick(3);

    // Back-to-back 01,02,03
    ovf_base = ovf_cnt;
    tx_data_f = 8'h01; tx_en_f = 1'b1;
    tick(1);
    tx_data_f = 8'h02;
    tick(1);
    tx_data_f = 8'h03;
    tick(1);
    tx_en_f = 1'b0;
    expect_frame(1'b0, 8'h01, BC, 1, "b2b 01");
    gap("b2b gap1");
    expect_frame(1'b0, 8'h02, BC, 0, "b2b 02");
    gap("b2b gap2");
    expect_frame(1'b0, 8'h03, BC, 0, "b2b 03");
    tick(1);
    chk(busy_f, 1'b0, "b2b busy end");
    chk(ovf_cnt - ovf_base, 0, "b2b ovf count");
    tick(3);

    // Overflow: 10..15 on consecutive cycles, only 15 dropped
    ovf_base = ovf_cnt;
    for (int k = 0; k < 6; k++) begin
      tx_data_f = 8'(8'h10 + k); tx_en_f = 1'b1;
      tick(1);
    end
    tx_en_f = 1'b0;
    chk(ovf_f, 1'b1, "ovf pulse");
    tick(1);
    chk(ovf_f, 1'b0, "ovf pulse end");
    expect_frame(1'b0, 8'h10, BC, 5, "ovf 10");
    for (int k = 1; k < 5; k++) begin
      gap($sformatf("ovf gap%0d", k));
      expect_frame(1'b0, 8'(8'h10 + k), BC, 0, $sformatf("ovf 1%0d", k));
    end
    tick(1);
    chk(busy_f, 1'b0, "ovf busy end");
    chk(ovf_cnt - ovf_base, 1, "ovf count");
    quiet(120, "ovf no sixth frame");

    // Push while full with a same-cycle pop
    ovf_base = ovf_cnt;
    tx_data_f = 8'h30; tx_en_f = 1'b1;
    tick(1);
    tx_en_f = 1'b0;
    tick(1);
    for (int k = 1; k < 5; k++) begin
      tx_data_f = 8'(8'h30 + k); tx_en_f = 1'b1;
      tick(1);
    end
    tx_en_f = 1'b0;
    expect_frame(1'b0, 8'h30, BC, 4, "pf 30");
    tx_data_f = 8'h77; tx_en_f = 1'b1;
    gap("pf gap0");
    tx_en_f = 1'b0;
    chk(ovf_f, 1'b0, "pf no ovf");
    for (int k = 1; k < 5; k++) begin
      expect_frame(1'b0, 8'(8'h30 + k), BC, 0, $sformatf("pf 3%0d", k));
      gap($sformatf("pf gap%0d", k));
    end
    expect_frame(1'b0, 8'h77, BC, 0, "pf 77");
    tick(1);
    chk(busy_f, 1'b0, "pf busy end");
    chk(ovf_cnt - ovf_base, 0, "pf ovf count");
    tick(3);

    // Reset during DATA bit 3 of FF with two bytes queued
    tx_data_f = 8'hFF; tx_en_f = 1'b1;
    tick(1);
    tx_data_f = 8'h11;
    tick(1);
    tx_data_f = 8'h22;
    tick(1);
    tx_en_f = 1'b0;
    tick(44);
    chk(busy_f, 1'b1, "rmf busy before");
    #2 rst_n = 1'b0;
    #1;
    chk(tx_f, 1'b1, "rmf tx async");
    chk(busy_f, 1'b0, "rmf busy async");
    tick(2);
    rst_n = 1'b1;
    quiet(250, "rmf no frames");
    chk(busy_f, 1'b0, "rmf busy after");

    // Reset during the start bit forces the line high at once
    tx_data_f = 8'h00; tx_en_f = 1'b1;
    tick(1);
    tx_en_f = 1'b0;
    tick(4);
    chk(tx_f, 1'b0, "rsb start low");
    #2 rst_n = 1'b0;
    #1;
    chk(tx_f, 1'b1, "rsb tx async");
    tick(2);
    rst_n = 1'b1;
    quiet(150, "rsb no frames");

    // Default rate: 5208 cycles per bit
    tx_data_s = 8'h55; tx_en_s = 1'b1;
    tick(1);
    tx_en_s = 1'b0;
    chk(tx_s, 1'b1, "slow tx e0");
    tick(1);
    expect_frame(1'b1, 8'h55, BC_SLOW, 0, "slow");
    chk(busy_s, 1'b1, "slow busy end frame");
    tick(1);
    chk(busy_s, 1'b0, "slow busy idle");
    chk(tx_s, 1'b1, "slow idle tx");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_byte_tx.md
Name: uart_byte_tx

Overview:
- UART 8N1 transmitter with a small byte queue.
- Sits directly downstream of the FIFO sum controller and consumes its tx_data/tx_en byte stream.
- Serialises the bytes onto the board tx pin.
- The queue absorbs back-to-back result bytes arriving faster than the line rate.

Parameters:
- CLK_FREQ, 50_000_000, sys_clk frequency in Hz.
- BAUD, 9600, line rate in bit/s. Cycles per bit BIT_CYC = CLK_FREQ/BAUD, integer division (5208 at defaults).
- DEPTH, 4, byte queue depth. Must be a power of 2 and at least 2.

Ports:
- sys_clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- tx_data  in  8  byte to send; sampled when tx_en=1.
- tx_en  in  1  single-cycle write strobe. Consecutive-cycle strobes are legal.
- tx  out  1  serial line, idle high.
- busy  out  1  high while the queue is non-empty or a frame is in progress.
- ovf  out  1  one-cycle pulse: the byte offered this cycle was dropped because the queue was full.

Behaviour:
- Reset (async):
  - tx=1, busy=0, ovf=0.
  - Queue emptied; state=IDLE; all counters cleared.
  - Reset mid-frame aborts the frame: tx returns to 1 immediately. No partial byte is resumed.
- Queue write:
  - tx_en=1 writes tx_data when count<DEPTH.
  - A write is also accepted when count==DEPTH if the FSM pops in the same cycle.
  - Otherwise the byte is dropped and ovf=1 on the next cycle.
  - Count range 0..DEPTH. Pointers wrap modulo DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If count>0: pop the head into shift register sh[7:0], clear bit counter and baud counter, go to START. On that same edge tx<=0.
  - START: hold tx=0 for BIT_CYC cycles. When baud_cnt==BIT_CYC-1: tx<=sh[0], go to DATA.
  - DATA: every BIT_CYC cycles shift sh right and drive the next bit, LSB first. After bit 7 has been held BIT_CYC cycles: tx<=1, go to STOP.
  - STOP: hold tx=1 for BIT_CYC cycles, then go to IDLE.
- Latency:
  - tx_en sampled at edge N with an empty queue and IDLE: queue written at N, pop and tx falling edge at N+1.
  - Frame length exactly 10*BIT_CYC cycles.
  - A queued next byte starts one cycle after STOP ends, giving an inter-frame gap of 1 clock.
- Counters:
  - baud_cnt width ceil(log2(BIT_CYC)); resets to 0 on every bit boundary.
  - bit_cnt is 3 bits, 0..7.
- tx is driven from a flop; no combinational path from any input to tx.
- busy = (state!=IDLE) | (count!=0), registered.
- Simultaneous push and pop: count unchanged; write pointer and read pointer both advance.
- tx_en is ignored while rst_n=0.

Decomposition:
- Shared package/include uart_defs:
  - State encoding: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3.
  - BIT_CYC computation.
  - Frame bit count constant FRAME_BITS=10.
- Sub-module sync_byte_fifo:
  - Parameter DEPTH; 8-bit data.
  - Ports: wr, din, rd, dout, count.
  - First-word-fall-through head.
  - Owns the pointer/count logic and the push-while-full-with-pop rule.

Test Plan:
- All tests use BAUD overridden so that BIT_CYC=10 (CLK_FREQ=50_000_000, BAUD=5_000_000) unless stated.
- Single byte: tx_en with tx_data=8'hA5 at edge 0 -> tx falls at edge 1. Line sequence 0,1,0,1,0,0,1,0,1,1, each held 10 cycles. busy high from edge 1 through edge 101, then low.
- Back-to-back: 8'h01, 8'h02, 8'h03 on three consecutive cycles -> three frames. 1-cycle idle-high gap between them. Bytes decode correctly in order. ovf never asserted.
- Overflow: DEPTH=4, send six bytes 8'h10..8'h15 on consecutive cycles starting at edge 0.
  - 8'h10 is popped at edge 1, so only one byte is dropped: 8'h15, with ovf=1 for exactly one cycle after its strobe.
  - Frames transmitted: 8'h10..8'h14.
- Push while full with pop:
  - Setup: fill the queue to 4 during a frame, then strobe 8'h77 in the exact cycle IDLE pops.
  - Required: byte accepted, no ovf, and 8'h77 transmitted last.
- Reset mid-frame: assert rst_n=0 during DATA bit 3 of 8'hFF, with 2 bytes queued.
  - tx=1 asynchronously; busy=0.
  - After release, no further frames are transmitted.
- Default rate: CLK_FREQ=50_000_000, BAUD=9600, send 8'h55 -> each bit held exactly 5208 cycles; frame is 52080 cycles.
